// File: rtl/wlm_sched_if.sv
// Requester, reducer and response signals of the reduction scheduler.
// master = requester/reducer side, slave = scheduler.
interface wlm_sched_if #(
    parameter int LOGQ  = 32,
    parameter int LOGQH = 15,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*LOGQH-1:0]  req_qH;
    logic [NREQ*2*LOGQ-1:0] req_C;
    logic [LOGQH-1:0]       red_qH;
    logic [2*LOGQ-1:0]      red_C;
    logic [LOGQ-1:0]        red_T;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [LOGQ-1:0]        rsp_T;

    modport master (
        output req_valid, req_qH, req_C, red_T,
        input  req_ready, red_qH, red_C, rsp_valid, rsp_id, rsp_T
    );

    modport slave (
        input  req_valid, req_qH, req_C, red_T,
        output req_ready, red_qH, red_C, rsp_valid, rsp_id, rsp_T
    );
endinterface

// File: rtl/wlm_sched.sv
// Round-robin scheduler feeding a fixed-latency reducer; a valid/ID shift
// register pairs each returning red_T with the requester that issued it.
//
// state   | meaning
// S_IDLE  | nothing in flight, waiting for a grant
// S_RUN   | operations in flight, grants allowed
// S_DRAIN | grants blocked, in-flight operations still retire
module wlm_sched #(
    parameter int  LOGQ  = 32,
    parameter int  LOGQH = 15,
    parameter int  NREQ  = 4,
    parameter int  LAT   = 6,
    localparam int IDW   = $clog2(NREQ),
    localparam int CW    = $clog2(LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    wlm_sched_if.slave    bus,
    input  logic          drain,
    output logic          idle,
    output logic [CW-1:0] inflight
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [LAT-1:0] vld_sr_q, vld_sr_d;
    logic [IDW-1:0] id_sr_q [LAT];
    logic [IDW-1:0] id_sr_d [LAT];

    logic           grant_ok, gnt_any, issue, retire;
    logic [IDW-1:0] gnt_idx, cand;

    // search starts one past the last granted requester
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        grant_ok      = !rst && !drain && (state_q != S_DRAIN);
        issue         = grant_ok && gnt_any;
        retire        = vld_sr_q[LAT-1] && !rst;
        bus.req_ready = '0;
        bus.red_qH    = '0;
        bus.red_C     = '0;
        if (issue) begin
            bus.req_ready[gnt_idx] = 1'b1;
            bus.red_qH = LOGQH'(bus.req_qH >> (int'(gnt_idx) * LOGQH));
            bus.red_C  = (2*LOGQ)'(bus.req_C >> (int'(gnt_idx) * 2 * LOGQ));
        end
        bus.rsp_valid = retire;
        bus.rsp_id    = id_sr_q[LAT-1];
        bus.rsp_T     = bus.red_T;
    end

    always_comb begin
        vld_sr_d[0] = issue;
        id_sr_d[0]  = gnt_idx;
        for (int k = 1; k < LAT; k++) begin
            vld_sr_d[k] = vld_sr_q[k-1];
            id_sr_d[k]  = id_sr_q[k-1];
        end

        ptr_d = ptr_q;
        if (issue)
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

        case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        state_d = state_q;
        if (drain) begin
            state_d = S_DRAIN;
        end else begin
            case (state_q)
                S_IDLE:  if (issue) state_d = S_RUN;
                S_RUN:   if (inflight_d == '0 && !issue) state_d = S_IDLE;
                S_DRAIN: state_d = (inflight_q != '0) ? S_RUN : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            inflight_q <= '0;
            vld_sr_q   <= '0;
            for (int k = 0; k < LAT; k++) id_sr_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            vld_sr_q   <= vld_sr_d;
            for (int k = 0; k < LAT; k++) id_sr_q[k] <= id_sr_d[k];
        end
    end

    assign idle     = (inflight_q == '0);
    assign inflight = inflight_q;
endmodule
